// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined register file and its scoreboard.
// Holds the default widths, the index of the hardwired zero register and
// the read-port bundle type that decode uses to carry an operand around.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int ZERO_IDX           = 0;

  // One decoded operand: which register, its value, and whether it must wait.
  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          stall;
  } read_port_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle between the pipeline (decode + write-back) and the register file.
//   master: decode/write-back side, drives addresses, write and issue strobes
//   slave : register file, returns read data, per-port stalls, pending_any
//
// Handshake semantics: there is no ready signal. regWrite and issue_valid are
// single-cycle strobes that the register file always accepts on the rising
// edge where they are high; read ports are pure combinational lookups.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg_num_1;
  logic [ADDR_WIDTH-1:0] read_reg_num_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  stall_1;
  logic                  stall_2;
  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] write_reg_num;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_reg_num;
  logic                  pending_any;

  modport master (
    output read_reg_num_1, read_reg_num_2, regWrite, write_reg_num,
           write_data, issue_valid, issue_reg_num,
    input  read_data_1, read_data_2, stall_1, stall_2, pending_any
  );

  modport slave (
    input  read_reg_num_1, read_reg_num_2, regWrite, write_reg_num,
           write_data, issue_valid, issue_reg_num,
    output read_data_1, read_data_2, stall_1, stall_2, pending_any
  );
endinterface

// File: rtl/regfile_scoreboard_bits.sv
// Per-register pending scoreboard, reusable by any register file.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr_en / clr_idx    : write-back retires the producer of clr_idx
//   set_en / set_idx    : an instruction writing set_idx issues
//   rd_addr_1/2         : operand addresses being read by decode
//   stall_1/2           : operand still waiting on an in-flight producer
//   pending_any         : at least one producer in flight
module regfile_scoreboard_bits
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic                  stall_1,
  output logic                  stall_2,
  output logic                  pending_any
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_IDX);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Clear first, then set: a new producer issued in the same cycle its
  // predecessor retires supersedes it, so the bit must end up set.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    if (set_en && !(ZERO_REG && set_idx == ZERO_ADDR)) pending_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // An operand whose producer is writing back right now is forwarded by the
  // bypass, so it does not need to wait.
  function automatic logic stall_for(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic                  pend,
                                     input logic                  wr_en,
                                     input logic [ADDR_WIDTH-1:0] wr_idx);
    logic s;
    s = pend && !(BYPASS && wr_en && wr_idx == addr);
    if (ZERO_REG && addr == ZERO_ADDR) s = 1'b0;
    return s;
  endfunction

  assign stall_1     = stall_for(rd_addr_1, pending_q[rd_addr_1], clr_en, clr_idx);
  assign stall_2     = stall_for(rd_addr_2, pending_q[rd_addr_2], clr_en, clr_idx);
  assign pending_any = |pending_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file for the pipelined core: two combinational read
// ports, one write port, write-to-read bypass, optional hardwired zero
// register, and a pending scoreboard that flags operands still in flight.
//   clk   : system clock, all state updates on the rising edge
//   reset : asynchronous active-low reset (clears array and pending bits)
//   rf    : slave side of regfile_scoreboard_if (reads, write-back, issue)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  rf
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_IDX);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_en;

  always_comb begin
    wr_en  = rf.regWrite && !(ZERO_REG && rf.write_reg_num == ZERO_ADDR);
    regs_d = regs_q;
    if (wr_en) regs_d[rf.write_reg_num] = rf.write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Zero register beats bypass, bypass beats the stored value.
  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] d;
    d = stored;
    if (BYPASS && rf.regWrite && rf.write_reg_num == addr) d = rf.write_data;
    if (ZERO_REG && addr == ZERO_ADDR) d = '0;
    return d;
  endfunction

  // While reset is low the bypass path is blocked too, so a write strobe
  // presented during reset cannot leak onto the read ports.
  assign rf.read_data_1 = reset ? read_sel(rf.read_reg_num_1, regs_q[rf.read_reg_num_1]) : '0;
  assign rf.read_data_2 = reset ? read_sel(rf.read_reg_num_2, regs_q[rf.read_reg_num_2]) : '0;

  regfile_scoreboard_bits #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_bits (
    .clk         (clk),
    .rst_n       (reset),
    .clr_en      (rf.regWrite),
    .clr_idx     (rf.write_reg_num),
    .set_en      (rf.issue_valid),
    .set_idx     (rf.issue_reg_num),
    .rd_addr_1   (rf.read_reg_num_1),
    .rd_addr_2   (rf.read_reg_num_2),
    .stall_1     (rf.stall_1),
    .stall_2     (rf.stall_2),
    .pending_any (rf.pending_any)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Inputs change just after the falling
// edge; outputs are sampled a few time units later, well clear of posedge.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int AW = DEFAULT_ADDR_WIDTH;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  read_port_t p1;

  regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();

  regfile_scoreboard #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ZERO_REG   (1'b1),
    .BYPASS     (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if.slave)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    rf_if.regWrite      = 1'b0;
    rf_if.write_reg_num = '0;
    rf_if.write_data    = '0;
    rf_if.issue_valid   = 1'b0;
    rf_if.issue_reg_num = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wb(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    rf_if.regWrite      = 1'b1;
    rf_if.write_reg_num = idx;
    rf_if.write_data    = data;
  endtask

  task automatic issue(input logic [AW-1:0] idx);
    rf_if.issue_valid   = 1'b1;
    rf_if.issue_reg_num = idx;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    idle_inputs();
    rf_if.read_reg_num_1 = 5'd2;
    rf_if.read_reg_num_2 = 5'd17;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("in_reset_pending_any", DW'(rf_if.pending_any), 32'd0);
    reset = 1'b1;
    #1;
    p1 = '{addr: rf_if.read_reg_num_1, data: rf_if.read_data_1, stall: rf_if.stall_1};
    check("reset_rd1",         p1.data,                   32'd0);
    check("reset_rd2",         rf_if.read_data_2,         32'd0);
    check("reset_stall1",      DW'(p1.stall),             32'd0);
    check("reset_stall2",      DW'(rf_if.stall_2),        32'd0);
    check("reset_pending_any", DW'(rf_if.pending_any),    32'd0);

    // Write with same-cycle bypass, then read back from the array
    wb(5'd3, 32'h0000_000F);
    rf_if.read_reg_num_1 = 5'd3;
    #1 check("bypass_rd1", rf_if.read_data_1, 32'h0000_000F);
    next_cycle();
    idle_inputs();
    #1 check("array_rd1_r3", rf_if.read_data_1, 32'h0000_000F);
    wb(5'd17, 32'h1234_5678);
    #1 check("bypass_rd2", rf_if.read_data_2, 32'h1234_5678);
    next_cycle();
    idle_inputs();
    #1 check("array_rd2_r17", rf_if.read_data_2, 32'h1234_5678);

    // Zero register ignores writes and issues
    wb(5'd0, 32'hDEAD_BEEF);
    issue(5'd0);
    rf_if.read_reg_num_1 = 5'd0;
    #1;
    check("zero_rd1_bypass", rf_if.read_data_1,      32'd0);
    check("zero_stall1",     DW'(rf_if.stall_1),     32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check("zero_rd1_array",   rf_if.read_data_1,     32'd0);
    check("zero_stall1_next", DW'(rf_if.stall_1),    32'd0);
    check("zero_pending_any", DW'(rf_if.pending_any), 32'd0);

    // RAW hazard on reg 5 resolved by write-back at t+3
    issue(5'd5);
    rf_if.read_reg_num_1 = 5'd5;
    next_cycle();
    idle_inputs();
    #1;
    check("hz_t1_stall1",      DW'(rf_if.stall_1),     32'd1);
    check("hz_t1_pending_any", DW'(rf_if.pending_any), 32'd1);
    next_cycle();
    #1 check("hz_t2_stall1", DW'(rf_if.stall_1), 32'd1);
    next_cycle();
    #1 check("hz_t3_stall1_pre", DW'(rf_if.stall_1), 32'd1);
    wb(5'd5, 32'h0000_0007);
    rf_if.read_reg_num_2 = 5'd5;
    #1;
    check("hz_t3_stall1", DW'(rf_if.stall_1), 32'd0);
    check("hz_t3_rd1",    rf_if.read_data_1,  32'd7);
    check("hz_t3_stall2", DW'(rf_if.stall_2), 32'd0);
    check("hz_t3_rd2",    rf_if.read_data_2,  32'd7);
    next_cycle();
    idle_inputs();
    #1;
    check("hz_t4_pending_any", DW'(rf_if.pending_any), 32'd0);
    check("hz_t4_rd1",         rf_if.read_data_1,      32'd7);

    // Set wins over clear on reg 9
    issue(5'd9);
    rf_if.read_reg_num_1 = 5'd9;
    next_cycle();
    idle_inputs();
    #1 check("sw_pre_stall1", DW'(rf_if.stall_1), 32'd1);
    wb(5'd9, 32'h0000_0010);
    issue(5'd9);
    #1;
    check("sw_same_stall1", DW'(rf_if.stall_1), 32'd0);
    check("sw_same_rd1",    rf_if.read_data_1,  32'h0000_0010);
    next_cycle();
    idle_inputs();
    #1;
    check("sw_next_stall1",      DW'(rf_if.stall_1),     32'd1);
    check("sw_next_rd1",         rf_if.read_data_1,      32'h0000_0010);
    check("sw_next_pending_any", DW'(rf_if.pending_any), 32'd1);

    // Double issue keeps the bit set; one write-back clears it
    issue(5'd9);
    next_cycle();
    idle_inputs();
    #1 check("dbl_stall1", DW'(rf_if.stall_1), 32'd1);
    wb(5'd9, 32'h0000_0011);
    next_cycle();
    idle_inputs();
    #1;
    check("dbl_clr_stall1",      DW'(rf_if.stall_1),     32'd0);
    check("dbl_clr_pending_any", DW'(rf_if.pending_any), 32'd0);
    check("dbl_clr_rd1",         rf_if.read_data_1,      32'h0000_0011);

    // Write-back to a register that was never pending
    wb(5'd12, 32'h0000_0055);
    rf_if.read_reg_num_1 = 5'd3;
    rf_if.read_reg_num_2 = 5'd12;
    next_cycle();
    idle_inputs();
    #1;
    check("np_rd2",         rf_if.read_data_2,      32'h0000_0055);
    check("np_stall2",      DW'(rf_if.stall_2),     32'd0);
    check("np_pending_any", DW'(rf_if.pending_any), 32'd0);
    check("np_rd1_r3",      rf_if.read_data_1,      32'h0000_000F);

    // Asynchronous reset between edges with regs 4 and 6 in flight
    wb(5'd4, 32'h0000_0022);
    issue(5'd4);
    next_cycle();
    idle_inputs();
    issue(5'd6);
    next_cycle();
    idle_inputs();
    rf_if.read_reg_num_1 = 5'd4;
    rf_if.read_reg_num_2 = 5'd6;
    #1;
    check("ar_pre_rd1",         rf_if.read_data_1,      32'h0000_0022);
    check("ar_pre_stall1",      DW'(rf_if.stall_1),     32'd1);
    check("ar_pre_stall2",      DW'(rf_if.stall_2),     32'd1);
    check("ar_pre_pending_any", DW'(rf_if.pending_any), 32'd1);
    wb(5'd4, 32'h0000_0099);
    #1 reset = 1'b0;
    #1;
    check("ar_low_rd1",         rf_if.read_data_1,      32'd0);
    check("ar_low_stall1",      DW'(rf_if.stall_1),     32'd0);
    check("ar_low_stall2",      DW'(rf_if.stall_2),     32'd0);
    check("ar_low_pending_any", DW'(rf_if.pending_any), 32'd0);
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    #1;
    check("ar_post_rd1",         rf_if.read_data_1,      32'd0);
    check("ar_post_rd2",         rf_if.read_data_2,      32'd0);
    check("ar_post_pending_any", DW'(rf_if.pending_any), 32'd0);
    rf_if.read_reg_num_1 = 5'd3;
    #1 check("ar_post_rd1_r3", rf_if.read_data_1, 32'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle datapath register file, for the pipelined processor.
- Provides an architectural register array with two combinational read ports and one write port, written on posedge.
- Adds a write-to-read bypass, a hardwired zero register, and a per-register pending scoreboard.
- Sits between decode (reads, issue) and write-back (write). The scoreboard raises per-port stall flags while an operand's producer is still in flight.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH (localparam).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to the read port.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_reg_num_1  in  ADDR_WIDTH  read port 1 address.
- read_reg_num_2  in  ADDR_WIDTH  read port 2 address.
- read_data_1  out  DATA_WIDTH  read port 1 data (combinational).
- read_data_2  out  DATA_WIDTH  read port 2 data (combinational).
- stall_1  out  1  operand 1 pending, not resolvable this cycle.
- stall_2  out  1  operand 2 pending, not resolvable this cycle.
- regWrite  in  1  write-back enable.
- write_reg_num  in  ADDR_WIDTH  write-back destination.
- write_data  in  DATA_WIDTH  write-back data.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_reg_num  in  ADDR_WIDTH  destination of the issuing instruction.
- pending_any  out  1  OR of all pending bits (drain/flush indicator).

Behaviour:
- Reset (reset=0, asynchronous): all registers cleared to 0 and all pending bits cleared.
  - Consequently read_data_1/2=0, stall_1/2=0 and pending_any=0 while reset is low.
  - Reset asserted mid-operation discards in-flight writes and issues immediately.
- Write: on posedge clk, if regWrite=1 then reg[write_reg_num] <= write_data.
  - Skipped when ZERO_REG=1 and write_reg_num=0.
  - Latency 1 cycle to the array.
- Read path, for each port independently:
  - If ZERO_REG and addr=0, data=0.
  - Else if BYPASS, regWrite=1 and write_reg_num=addr, data=write_data.
  - Else data=reg[addr].
  - Purely combinational; no read enable.
- Scoreboard: one pending bit per register. On posedge clk:
  - The bit for write_reg_num is cleared if regWrite=1.
  - The bit for issue_reg_num is set if issue_valid=1.
  - Simultaneous clear and set of the same index: set wins, because the new producer supersedes the retiring one.
  - Index 0 is never set when ZERO_REG=1.
- Stall rule: stall_n = pending[addr_n] AND NOT(BYPASS AND regWrite AND write_reg_num=addr_n).
  - Forced to 0 for address 0 when ZERO_REG=1.
  - With BYPASS=0, a register being written this cycle still stalls; it is readable the following cycle.
- Double issue to an already-pending register: the bit stays set. There is no counting; one writeback clears it. Decode must not issue a second producer before the first retires, and the bench checks the bit remains 1.
- Writeback to a non-pending register is legal: data is written and the bit stays 0.
- pending_any is combinational from the registered bits.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - the ZERO_IDX constant.
  - a read-port struct type {addr, data, stall} used by decode.
- One natural sub-module: regfile_scoreboard_bits. It holds the pending vector, set/clear priority, stall generation and pending_any, so the scoreboard can be reused by a future FP register file.
- Array, bypass and zero-register logic remain in the top.

Test Plan:
- Reset then read: reset low 2 cycles then high; read addrs 2 and 17 -> read_data_1=0, read_data_2=0, stall_1=stall_2=0, pending_any=0.
- Write/read with bypass: regWrite=1, write_reg_num=3, write_data=32'h0000_000F, read_reg_num_1=3 in the same cycle -> read_data_1=0xF combinationally. Next cycle, with regWrite=0 -> still 0xF.
- Zero register: write 32'hDEAD_BEEF to reg 0 and issue reg 0 -> read_data of addr 0 = 0, stall=0, pending_any=0.
- Scoreboard hazard: issue reg 5 at cycle t; read reg 5 at t+1..t+3 -> stall_1=1. At t+3, regWrite to reg 5 with data 0x7 -> stall_1=0 and read_data_1=7 that cycle. At t+4 -> pending_any=0.
- Set-wins collision: reg 9 pending; in one cycle regWrite reg 9 data 0x10 and issue_valid reg 9 -> next cycle reg 9 pending=1, array holds 0x10, stall on reads of 9 = 1.
- Async reset mid-flight: regs 4 and 6 pending, reg 4 = 0x22; drop reset between clock edges -> outputs zero and pending_any=0 before the next posedge; a regWrite presented during reset has no effect.
